// File: rtl/player_ctrl_pkg.sv
// player_ctrl_pkg: register map, STATUS bit positions and motion FSM states
// shared by the per-player paddle controllers.
`default_nettype none

package player_ctrl_pkg;

  localparam logic [1:0] REG_POS    = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_STEP   = 2'd3;

  localparam int ST_AT_MIN = 0;
  localparam int ST_AT_MAX = 1;
  localparam int ST_MOVING = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/player_tick_gen.sv
// player_tick_gen: free-running divider producing a one-cycle tick every
// TICK_DIV clocks (high while the count equals TICK_DIV-1).
`default_nettype none

module player_tick_gen #(
  parameter int TICK_DIV = 833333
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int            CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] c_last = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_last);

endmodule

`default_nettype wire

// File: rtl/player_y_ctrl.sv
// player_y_ctrl: one player's paddle Y position, driven by Avalon-MM register
// writes and tick-stepped button motion, clamped to [Y_MIN, Y_MAX].
`default_nettype none

module player_y_ctrl
  import player_ctrl_pkg::*;
#(
  parameter int Y_MIN    = 0,
  parameter int Y_MAX    = 420,
  parameter int TICK_DIV = 833333,
  parameter int STEP_RST = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        btn_up_n,
  input  logic        btn_down_n,
  output logic [9:0]  y_out,
  output logic        moving
);

  localparam logic [9:0]  c_y_min   = 10'(Y_MIN);
  localparam logic [9:0]  c_y_max   = 10'(Y_MAX);
  localparam logic [31:0] c_y_min32 = 32'(Y_MIN);
  localparam logic [31:0] c_y_max32 = 32'(Y_MAX);
  localparam logic [3:0]  c_step_rst = 4'(STEP_RST);

  logic       w_tick;
  logic [1:0] r_up_sync;
  logic [1:0] r_dn_sync;
  logic       w_up_s;
  logic       w_dn_s;
  state_t     r_state;
  state_t     w_state_next;
  logic       r_hw_en;
  logic [3:0] r_step;
  logic [9:0] r_y;
  logic       w_wr;
  logic [9:0] w_pos_wr_val;
  logic [10:0] w_y_dec;
  logic [10:0] w_y_inc;
  logic [9:0] w_y_moved;
  logic       w_pos_below_min;
  logic       w_dec_below_min;
  logic       w_at_min;
  logic       w_at_max;

  player_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (w_tick)
  );

  // Buttons are active low; the synchronizer carries the pressed (high) sense.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_up_sync <= 2'b00;
      r_dn_sync <= 2'b00;
    end else begin
      r_up_sync <= {r_up_sync[0], ~btn_up_n};
      r_dn_sync <= {r_dn_sync[0], ~btn_down_n};
    end
  end

  assign w_up_s = r_up_sync[1];
  assign w_dn_s = r_dn_sync[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = IDLE;
    if (!r_hw_en) begin
      w_state_next = IDLE;
    end else if (w_up_s && !w_dn_s) begin
      w_state_next = UP;
    end else if (w_dn_s && !w_up_s) begin
      w_state_next = DOWN;
    end else begin
      w_state_next = IDLE;
    end
  end

  assign w_y_dec = {1'b0, r_y} - {7'd0, r_step};
  assign w_y_inc = {1'b0, r_y} + {7'd0, r_step};

  // A zero lower bound needs no comparison (it would be constant for unsigned).
  generate
    if (Y_MIN > 0) begin : g_min_cmp
      assign w_pos_below_min = (writedata < c_y_min32);
      assign w_dec_below_min = (w_y_dec < {1'b0, c_y_min});
    end else begin : g_min_zero
      assign w_pos_below_min = 1'b0;
      assign w_dec_below_min = 1'b0;
    end
  endgenerate

  always_comb begin
    w_y_moved = r_y;
    case (r_state)
      UP: begin
        if (w_y_dec[10] || w_dec_below_min) begin
          w_y_moved = c_y_min;
        end else begin
          w_y_moved = w_y_dec[9:0];
        end
      end
      DOWN: begin
        if (w_y_inc > {1'b0, c_y_max}) begin
          w_y_moved = c_y_max;
        end else begin
          w_y_moved = w_y_inc[9:0];
        end
      end
      default: w_y_moved = r_y;
    endcase
  end

  assign w_wr = chipselect && !write_n;

  always_comb begin
    w_pos_wr_val = writedata[9:0];
    if (writedata > c_y_max32) begin
      w_pos_wr_val = c_y_max;
    end else if (w_pos_below_min) begin
      w_pos_wr_val = c_y_min;
    end
  end

  // A CPU position write in a tick cycle overrides that tick's step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_y <= c_y_min;
    end else if (w_wr && (address == REG_POS)) begin
      r_y <= w_pos_wr_val;
    end else if (w_tick) begin
      r_y <= w_y_moved;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hw_en <= 1'b0;
      r_step  <= c_step_rst;
    end else if (w_wr) begin
      if (address == REG_CTRL) begin
        r_hw_en <= writedata[0];
      end
      if (address == REG_STEP) begin
        r_step <= writedata[3:0];
      end
    end
  end

  assign w_at_min = (r_y == c_y_min);
  assign w_at_max = (r_y == c_y_max);

  always_comb begin
    readdata = '0;
    case (address)
      REG_POS:    readdata[9:0] = r_y;
      REG_CTRL:   readdata[0]   = r_hw_en;
      REG_STATUS: begin
        readdata[ST_AT_MIN] = w_at_min;
        readdata[ST_AT_MAX] = w_at_max;
        readdata[ST_MOVING] = moving;
      end
      REG_STEP:   readdata[3:0] = r_step;
      default:    readdata = '0;
    endcase
  end

  assign y_out  = r_y;
  assign moving = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_player_y_ctrl.sv
// tb_player_y_ctrl: directed, scoreboard-driven bench for player_y_ctrl with
// TICK_DIV=4 (reset, write clamping, motion, boundaries, collision, reset).
`default_nettype none

module tb_player_y_ctrl;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        btn_up_n;
  logic        btn_down_n;
  logic [9:0]  y_out;
  logic        moving;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];

  logic [1:0] tb_phase;

  player_y_ctrl #(
    .Y_MIN    (0),
    .Y_MAX    (420),
    .TICK_DIV (4),
    .STEP_RST (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .btn_up_n   (btn_up_n),
    .btn_down_n (btn_down_n),
    .y_out      (y_out),
    .moving     (moving)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected divider phase: value of the tick count during the current cycle.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) tb_phase <= 2'd0;
    else          tb_phase <= tb_phase + 2'd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic sync_phase(input logic [1:0] p);
    for (int n = 0; n < 8 && tb_phase != p; n++) @(negedge clk);
  endtask

  // Park the paddle at start with motion disabled, set the buttons, then
  // enable in a phase-0 cycle so the first step lands four edges later.
  task automatic run_motion(input logic [9:0] start, input logic up_n,
                            input logic dn_n, input logic exp_mv);
    exp_t e;
    int   n;
    wr(2'd1, 32'd0);
    @(negedge clk);
    wr(2'd0, 32'(start));
    btn_up_n   = up_n;
    btn_down_n = dn_n;
    repeat (3) @(negedge clk);
    sync_phase(2'd0);
    wr(2'd1, 32'd1);
    n = sb.size();
    for (int i = 0; i < n; i++) begin
      repeat ((i == 0) ? 3 : 4) @(negedge clk);
      e = sb.pop_front();
      chk(e.tag, 32'(y_out), e.val);
      chk({e.tag, "_mv"}, 32'(moving), 32'(exp_mv));
    end
  endtask

  logic [31:0] rdv;

  initial begin
    reset_n    = 1'b0;
    address    = 2'd3;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    btn_up_n   = 1'b1;
    btn_down_n = 1'b1;

    #12;
    chk("rst_y", 32'(y_out), 32'd0);
    chk("rst_mv", 32'(moving), 32'd0);
    rd(2'd3, rdv); chk("rst_step", rdv, 32'd4);
    rd(2'd0, rdv); chk("rst_pos", rdv, 32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_y", 32'(y_out), 32'd0);

    wr(2'd0, 32'd1000);
    rd(2'd0, rdv); chk("clamp_pos", rdv, 32'd420);
    rd(2'd2, rdv); chk("clamp_status", rdv, 32'h2);
    wr(2'd0, 32'd100);
    chk("wr_y", 32'(y_out), 32'd100);

    push("down1", 32'd104); push("down2", 32'd108); push("down3", 32'd112);
    run_motion(10'd100, 1'b1, 1'b0, 1'b1);

    push("up1", 32'd96); push("up2", 32'd92); push("up3", 32'd88);
    run_motion(10'd100, 1'b0, 1'b1, 1'b1);

    push("both1", 32'd100); push("both2", 32'd100);
    run_motion(10'd100, 1'b0, 1'b0, 1'b0);

    push("min1", 32'd0); push("min2", 32'd0);
    run_motion(10'd2, 1'b0, 1'b1, 1'b1);
    rd(2'd2, rdv); chk("min_status", rdv, 32'h5);

    push("max1", 32'd420); push("max2", 32'd420);
    run_motion(10'd418, 1'b1, 1'b0, 1'b1);
    rd(2'd2, rdv); chk("max_status", rdv, 32'h6);

    wr(2'd3, 32'd0);
    rd(2'd3, rdv); chk("step0_rd", rdv, 32'd0);
    push("step0_1", 32'd250); push("step0_2", 32'd250);
    run_motion(10'd250, 1'b1, 1'b0, 1'b1);
    wr(2'd3, 32'd4);

    push("coll_pre", 32'd304);
    run_motion(10'd300, 1'b1, 1'b0, 1'b1);
    sync_phase(2'd3);
    wr(2'd0, 32'd200);
    chk("coll_wr", 32'(y_out), 32'd200);
    repeat (4) @(negedge clk);
    chk("coll_next", 32'(y_out), 32'd204);

    chk("mid_mv_pre", 32'(moving), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_y", 32'(y_out), 32'd0);
    chk("mid_rst_mv", 32'(moving), 32'd0);
    rd(2'd1, rdv); chk("mid_rst_ctrl", rdv, 32'd0);
    rd(2'd3, rdv); chk("mid_rst_step", rdv, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
